// File: rtl/serial_addsub_ctrl_311.sv
// Bit-serial add/subtract controller driving one full-adder cell over WIDTH cycles.
// Optional running-accumulator mode (acc port) is enabled with `define SERIAL_ACC_EN.
module serial_addsub_ctrl_311_chk (
  input logic clk,
  input logic rst_n,
  input logic busy,
  input logic done
);
  // done is only ever raised while busy
  a_done_busy: assert property (@(posedge clk) disable iff (!rst_n) done |-> busy);
  // done never lasts more than one cycle
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
endmodule

module serial_addsub_ctrl_311 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ACC_EN
  input  logic             acc,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   op_a_r;
  logic [WIDTH-1:0]   op_b_r;
  logic               carry_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   result_r;
  logic               cout_r;
  logic               ovf_r;
  logic               busy_r;
  logic               done_r;
  logic               sum_s;
  logic               cy_s;
  logic               last_s;
  logic [WIDTH-1:0]   op_a_load_s;

  // Full-adder cell, last-bit detect and operand-A source selection
  always_comb begin
    sum_s       = op_a_r[0] ^ op_b_r[0] ^ carry_r;
    cy_s        = (op_a_r[0] & op_b_r[0]) | (op_a_r[0] & carry_r) | (op_b_r[0] & carry_r);
    last_s      = (cnt_r == CNT_W'(WIDTH - 1));
    op_a_load_s = a;
`ifdef SERIAL_ACC_EN
    if (acc) begin
      op_a_load_s = result_r;
    end else begin
      op_a_load_s = a;
    end
`endif
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      op_a_r   <= '0;
      op_b_r   <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      result_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            // Subtraction becomes a + ~b + 1: invert B and seed the carry with 1
            op_a_r  <= op_a_load_s;
            op_b_r  <= sub ? ~b : b;
            carry_r <= sub;
            cnt_r   <= '0;
          end
        end
        ST_RUN: begin
          result_r <= {sum_s, result_r[WIDTH-1:1]};
          op_a_r   <= {1'b0, op_a_r[WIDTH-1:1]};
          op_b_r   <= {1'b0, op_b_r[WIDTH-1:1]};
          carry_r  <= cy_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (last_s) begin
            // carry_r here is the carry into the MSB
            cout_r <= cy_s;
            ovf_r  <= carry_r ^ cy_s;
          end
        end
        ST_DONE: begin
          cnt_r <= '0;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
  assign ovf    = ovf_r;

  serial_addsub_ctrl_311_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy_r),
    .done  (done_r)
  );

endmodule

// File: tb/tb_serial_addsub_ctrl_311.sv
// Scoreboard bench for serial_addsub_ctrl_311: expected results queued at start, checked on done.
module tb_serial_addsub_ctrl_311;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         acc = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           n_push = 0;
  int           n_done = 0;
  logic         prev_done = 1'b0;
  logic [W-1:0] acc_model = '0;

  serial_addsub_ctrl_311 #(.WIDTH(W), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
`ifdef SERIAL_ACC_EN
    .acc    (acc),
`endif
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
    exp_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb    = ms ? ~mb : mb;
    full  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ms};
    r.res = full[W-1:0];
    r.co  = full[W];
    r.ov  = (ma[W-1] == bb[W-1]) && (r.res[W-1] != ma[W-1]);
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      n_done++;
      check_eq("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("result", {24'd0, result}, {24'd0, e.res});
        check_eq("cout", {31'd0, cout}, {31'd0, e.co});
        check_eq("ovf", {31'd0, ovf}, {31'd0, e.ov});
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_eq("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    if (!done) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_exp(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is, input logic iacc);
    exp_t e;
    e = model(iacc ? acc_model : ia, ib, is);
    sb.push_back(e);
    acc_model = e.res;
    n_push++;
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                       input logic iacc, input bit push);
    wait_idle();
    @(negedge clk);
    a = ia; b = ib; sub = is; acc = iacc; start = 1'b1;
    if (push) push_exp(ia, ib, is, iacc);
    @(negedge clk);
    start = 1'b0;
    a = ~ia; b = ~ib; sub = ~is; acc = 1'b0;
    check_eq("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  logic [W-1:0] ta [5] = '{8'h35, 8'hFF, 8'h7F, 8'h10, 8'h80};
  logic [W-1:0] tb [5] = '{8'h4A, 8'h01, 8'h01, 8'h20, 8'h01};
  logic         ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", {24'd0, result}, 32'd0);
    check_eq("rst_cout", {31'd0, cout}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);

    // directed table then random operands
    for (int i = 0; i < 5; i++) begin
      issue(ta[i], tb[i], ts[i], 1'b0, 1'b1);
      wait_done(n);
      check_eq("latency", n, W);
    end
    for (int i = 0; i < 6; i++) begin
      issue(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      wait_done(n);
      check_eq("latency_rand", n, W);
    end

    // start while busy is ignored
    issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check_eq("latency_ignored_start", n, W - 3);

    // start held high: accepted every W+2 cycles
    wait_idle();
    @(negedge clk);
    a = 8'h21; b = 8'h0F; sub = 1'b0; acc = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(8'h21, 8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_done(n);
      check_eq("b2b_interval", n, (i == 0) ? W + 1 : W + 2);
    end
    start = 1'b0;

    // reset in the middle of RUN discards the operation
    issue(8'h55, 8'h22, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acc_model = '0;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_result", {24'd0, result}, 32'd0);
    check_eq("midrst_cout", {31'd0, cout}, 32'd0);
    check_eq("midrst_ovf", {31'd0, ovf}, 32'd0);
    repeat (12) @(negedge clk);
    issue(8'h0A, 8'h05, 1'b1, 1'b0, 1'b1);
    wait_done(n);
    check_eq("latency_after_rst", n, W);

`ifdef SERIAL_ACC_EN
    issue(8'h05, 8'h03, 1'b0, 1'b0, 1'b1);
    wait_done(n);
    issue(8'hAA, 8'h10, 1'b0, 1'b1, 1'b1);
    wait_done(n);
    issue(8'hAA, 8'h08, 1'b1, 1'b1, 1'b1);
    wait_done(n);
`endif

    repeat (12) @(negedge clk);
    check_eq("queue_empty", sb.size(), 32'd0);
    check_eq("done_count", n_done, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_addsub_ctrl_311.md
Name: serial_addsub_ctrl_311

Overview:
Bit-serial adder/subtractor controller that drives a single full-adder cell (sum/carry from a, b, c) over WIDTH cycles. It latches two operands on a start pulse, shifts them LSB-first through the cell, and holds the carry in a flip-flop between bits. It collects the sum bits into a result register and flags completion with a one-cycle done pulse. It lets a wide add/subtract share one full adder instead of WIDTH copies.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32
CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  request an operation; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b; latched with start
a  input  WIDTH  operand A; latched with start
b  input  WIDTH  operand B; latched with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result/cout/ovf valid from this cycle
result  output  WIDTH  sum/difference; held until next accepted start
cout  output  1  carry-out (add) / no-borrow (sub)
ovf  output  1  two's-complement overflow

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, carry FF=0, counter=0. Takes priority over every other input, including in the middle of an operation; a partial operation is discarded and no done is produced.
- FSM states and transitions:
  - IDLE: start=1 at edge k moves to RUN.
    - On that edge: opA<=a; opB<=sub ? ~b : b; carry<=sub; count<=0; sub latched.
    - result/cout/ovf are not cleared at start; they keep their old values until the final edge.
  - RUN: on each edge, the cell evaluates opA[0], opB[0], carry:
    - sum bit shifts into result MSB (result<={s, result[WIDTH-1:1]}).
    - opA and opB shift right; carry<=cy; count increments.
    - On the edge where count==WIDTH-1: cout<=cy, ovf<=carry^cy (carry into MSB xor carry out), and the FSM moves to DONE.
    - RUN therefore lasts exactly WIDTH edges (k+1..k+WIDTH).
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge k; done high in the cycle after edge k+WIDTH; next start is accepted at edge k+WIDTH+2 at the earliest.
- start while busy=1 is ignored (no queueing). a, b and sub may change freely after the accepting edge.
- done and busy are registered outputs (no combinational path from inputs).
- Subtraction is a + ~b + 1. cout=1 means a>=b (unsigned).
- Arithmetic is modulo 2**WIDTH. No saturation.

Optional Feature:
SERIAL_ACC_EN
- Defined: adds input port acc (1 bit). When start=1 and acc=1 in IDLE, operand A is loaded from the current result instead of from a, giving result = result ± b (running accumulator). acc=0 behaves exactly as without the macro.
- Undefined: no acc port; operand A is always a.

Test Plan:
- Reset then add, WIDTH=8: a=0x35, b=0x4A, sub=0, start 1 cycle -> busy for 9 cycles, done pulse after edge k+8, result=0x7F, cout=0, ovf=0.
- Unsigned wrap: a=0xFF, b=0x01, add -> result=0x00, cout=1, ovf=0. Signed overflow: a=0x7F, b=0x01, add -> result=0x80, cout=0, ovf=1.
- Subtract: a=0x10, b=0x20, sub=1 -> result=0xF0, cout=0, ovf=0. Also a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, ovf=1.
- Start while busy: start again 3 cycles after acceptance with a=0x01, b=0x01 -> ignored; first result unaffected; exactly one done pulse. Back-to-back: start held high continuously -> accepted every WIDTH+2 cycles.
- Reset mid-operation: rst_n=0 for 1 cycle at RUN bit 4 -> next cycle busy=0, done=0, result=0, cout=0, ovf=0, no done pulse. A fresh start afterwards completes normally.
- SERIAL_ACC_EN: a=0x05, b=0x03, add -> 0x08. Then acc=1, b=0x10, add -> 0x18. Then acc=1, sub=1, b=0x08 -> 0x10, cout=1.
